// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD clock-phase interface: phase-vector bit positions,
// default timing/width constants and the readout sequencer state encoding.
package ccd_pkg;

  localparam int SETTLE_CYC_DEF = 4;
  localparam int CNT_W_DEF      = 12;

  // Bit positions of each phase inside the 4-bit phase vector.
  localparam int PH_P   = 0;
  localparam int PH_L1  = 1;
  localparam int PH_L2  = 2;
  localparam int PH_R   = 3;
  localparam int PH_NUM = 4;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_R_FALL  = 3'd1,
    ST_SETTLE_RST   = 3'd2,
    ST_WAIT_L2_FALL = 3'd3,
    ST_SETTLE_SIG   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/ccd_edge_detect.sv
// Per-bit edge detector: registers the previous value of each input bit and
// reports rise/fall combinationally against the current input.
module ccd_edge_detect #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic [W-1:0] i_cur,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] prev;

  // NOTE: prev has no reset branch on purpose; it loads the live input every
  // cycle, which is exactly the "history = current input" state wanted out of reset.
  always_ff @(posedge i_clk) begin
    prev <= i_cur;
  end

  assign o_rise = i_cur & ~prev;
  assign o_fall = ~i_cur & prev;

endmodule

// File: rtl/ccd_readout_sequencer.sv
// CCD readout sequencer: follows the phase waveforms from the signal generator,
// issues CDS sample strobes, tracks pixel/line position and flags phase-order faults.
module ccd_readout_sequencer
  import ccd_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_phi_p,
  input  logic             i_phi_l1,
  input  logic             i_phi_l2,
  input  logic             i_phi_r,
  output logic             o_smp_rst,
  output logic             o_smp_sig,
  output logic             o_pix_done,
  output logic [CNT_W-1:0] o_pix_idx,
  output logic [CNT_W-1:0] o_line_idx,
  output logic             o_busy,
  output logic             o_err_seq,
  output logic             o_err_ovl
);

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PIX_MAX     = '1;

  logic [PH_NUM-1:0] phi, rise, fall;
  logic              p_rise, r_rise, r_fall, l2_fall;
  logic              unused_edges;

  seq_state_e state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       smp_rst_nx, smp_sig_nx, err_seq_set;

  assign phi[PH_P]  = i_phi_p;
  assign phi[PH_L1] = i_phi_l1;
  assign phi[PH_L2] = i_phi_l2;
  assign phi[PH_R]  = i_phi_r;

  ccd_edge_detect #(.W(PH_NUM)) u_edge (
    .i_clk  (i_clk),
    .i_cur  (phi),
    .o_rise (rise),
    .o_fall (fall)
  );

  assign p_rise  = rise[PH_P];
  assign r_rise  = rise[PH_R];
  assign r_fall  = fall[PH_R];
  assign l2_fall = fall[PH_L2];
  assign unused_edges = ^{rise[PH_L1], fall[PH_L1], rise[PH_L2], fall[PH_P]};

  // NOTE: every always_comb output gets a default before any branch so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    smp_rst_nx  = 1'b0;
    smp_sig_nx  = 1'b0;
    err_seq_set = 1'b0;
    if (p_rise) begin
      // A line transfer aborts any pixel in flight.
      state_nx    = ST_IDLE;
      err_seq_set = (state != ST_IDLE);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (r_rise) state_nx = ST_WAIT_R_FALL;
        end
        ST_WAIT_R_FALL: begin
          if (r_rise || l2_fall) begin
            err_seq_set = 1'b1;
            state_nx    = ST_IDLE;
          end else if (r_fall) begin
            state_nx = ST_SETTLE_RST;
            cnt_nx   = SETTLE_LOAD;
          end
        end
        ST_SETTLE_RST: begin
          if (r_rise || l2_fall) begin
            err_seq_set = 1'b1;
            state_nx    = ST_IDLE;
          end else if (cnt == 8'd0) begin
            smp_rst_nx = 1'b1;
            state_nx   = ST_WAIT_L2_FALL;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
        ST_WAIT_L2_FALL: begin
          if (r_rise) begin
            err_seq_set = 1'b1;
            state_nx    = ST_IDLE;
          end else if (l2_fall) begin
            state_nx = ST_SETTLE_SIG;
            cnt_nx   = SETTLE_LOAD;
          end
        end
        ST_SETTLE_SIG: begin
          // Completion beats a coincident phi_r rise, which then starts the next pixel.
          if (cnt == 8'd0) begin
            smp_sig_nx = 1'b1;
            state_nx   = r_rise ? ST_WAIT_R_FALL : ST_IDLE;
          end else if (r_rise) begin
            err_seq_set = 1'b1;
            state_nx    = ST_IDLE;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_enable) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      o_smp_rst  <= 1'b0;
      o_smp_sig  <= 1'b0;
      o_pix_done <= 1'b0;
      o_pix_idx  <= '0;
      o_line_idx <= '0;
      o_busy     <= 1'b0;
      o_err_seq  <= 1'b0;
      o_err_ovl  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      o_smp_rst  <= smp_rst_nx;
      o_smp_sig  <= smp_sig_nx;
      o_pix_done <= smp_sig_nx;
      o_busy     <= (state_nx != ST_IDLE);
      if (err_seq_set)         o_err_seq <= 1'b1;
      if (i_phi_l1 && i_phi_l2) o_err_ovl <= 1'b1;
      if (p_rise) begin
        o_pix_idx  <= '0;
        o_line_idx <= o_line_idx + CNT_W'(1);
      end else if (o_pix_done && (o_pix_idx != PIX_MAX)) begin
        o_pix_idx <= o_pix_idx + CNT_W'(1);
      end
    end
  end

endmodule
